complex_mult_scoreboard: RTL

COMPLEX_MULT_SCOREBOARD -- requirements
Module: complex_mult_scoreboard

---
 rtl/complex_mult_scoreboard.sv | 117 +++++++++++
 1 files changed

// File: rtl/complex_mult_scoreboard.sv
// Scoreboard for a complex multiplier: predicts each accepted operand pair's product,
// queues predictions in order and compares them against returned results.
module complex_mult_scoreboard #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int SIGNED_MODE = 0,
  parameter int TIMEOUT     = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          sw_rst,
  input  logic                          op_val,
  input  logic                          op_ready,
  input  logic [DATA_WIDTH-1:0]         op_1_re,
  input  logic [DATA_WIDTH-1:0]         op_1_im,
  input  logic [DATA_WIDTH-1:0]         op_2_re,
  input  logic [DATA_WIDTH-1:0]         op_2_im,
  input  logic                          res_val,
  input  logic                          res_ready,
  input  logic [2*DATA_WIDTH-1:0]       result_re,
  input  logic [2*DATA_WIDTH-1:0]       result_im,
  output logic [CNT_WIDTH-1:0]          pass_cnt,
  output logic [CNT_WIDTH-1:0]          fail_cnt,
  output logic [$clog2(DEPTH):0]        outstanding,
  output logic                          mismatch,
  output logic                          overflow_err,
  output logic                          underflow_err,
  output logic                          timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int RW = 2 * DATA_WIDTH;
  localparam int AW = $clog2(TIMEOUT + 1);
  localparam logic [OW-1:0] FULL_C = OW'(DEPTH);
  localparam logic [AW-1:0] TMO_C  = AW'(TIMEOUT);

  // The low RW bits of the (RW+1)-bit sum/difference equal modulo-2^RW arithmetic,
  // so operands are extended straight to RW bits.
  function automatic logic [RW-1:0] ext(input logic [DATA_WIDTH-1:0] v);
    if (SIGNED_MODE != 0) ext = {{DATA_WIDTH{v[DATA_WIDTH-1]}}, v};
    else                  ext = {{DATA_WIDTH{1'b0}}, v};
  endfunction

  logic [RW-1:0] r_mem_re [DEPTH];
  logic [RW-1:0] r_mem_im [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW-1:0] r_age;

  logic          w_push_hs, w_res_hs, w_empty, w_full, w_push, w_pop, w_match;
  logic [RW-1:0] w_pred_re, w_pred_im;

  assign w_pred_re = ext(op_1_re) * ext(op_2_re) - ext(op_1_im) * ext(op_2_im);
  assign w_pred_im = ext(op_1_re) * ext(op_2_im) + ext(op_1_im) * ext(op_2_re);

  assign w_push_hs = op_val && op_ready;
  assign w_res_hs  = res_val && res_ready;
  assign w_empty   = (outstanding == '0);
  assign w_full    = (outstanding == FULL_C);
  assign w_pop     = w_res_hs && !w_empty;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO is legal then.
  assign w_push    = w_push_hs && (!w_full || w_pop);
  assign w_match   = (result_re == r_mem_re[r_rd_ptr]) && (result_im == r_mem_im[r_rd_ptr]);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_re[r_wr_ptr] <= w_pred_re;
      r_mem_im[r_wr_ptr] <= w_pred_im;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || sw_rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_age         <= '0;
      pass_cnt      <= '0;
      fail_cnt      <= '0;
      outstanding   <= '0;
      mismatch      <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push_hs && w_full && !w_pop) overflow_err <= 1'b1;
      if (w_res_hs && w_empty) underflow_err <= 1'b1;

      if (w_pop) begin
        if (w_match) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_WIDTH'(1);
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_WIDTH'(1);
          mismatch <= 1'b1;
        end
      end

      case ({w_push, w_pop})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase

      // Age tracks how long the head prediction has waited; it saturates at TIMEOUT.
      if (w_pop || w_empty) begin
        r_age <= '0;
      end else begin
        if (r_age != TMO_C) r_age <= r_age + AW'(1);
        if (r_age >= TMO_C - AW'(1)) timeout_err <= 1'b1;
      end
    end
  end

endmodule
